// File: rtl/hv_pair_streamer.sv
// Streams paired A/B hypervector elements from element memory into the similarity accumulator.
// Optional ready/done watchdog enabled by defining HV_PAIR_STREAMER_WATCHDOG_EN.
module hv_pair_streamer #(
    parameter int HV_DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int LEN_WIDTH      = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    a_base,
    input  logic [ADDR_WIDTH-1:0]    b_base,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     mem_rd,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [HV_DATA_WIDTH-1:0] mem_rdata,
    output logic                     sim_valid,
    output logic                     sim_first,
    output logic                     sim_last,
    output logic [HV_DATA_WIDTH-1:0] sim_data,
    input  logic                     sim_ready,
    input  logic                     sim_done,
    input  logic [HV_DATA_WIDTH-1:0] sim_AA,
    input  logic [HV_DATA_WIDTH-1:0] sim_BB,
    input  logic [HV_DATA_WIDTH-1:0] sim_AB,
    output logic [HV_DATA_WIDTH-1:0] res_AA,
    output logic [HV_DATA_WIDTH-1:0] res_BB,
    output logic [HV_DATA_WIDTH-1:0] res_AB,
    output logic                     result_valid,
    output logic                     error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_LOAD,
        S_WAIT_RDY,
        S_SEND_A,
        S_SEND_B,
        S_GUARD,
        S_WAIT_DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDR_WIDTH-1:0]    a_base_r;
    logic [ADDR_WIDTH-1:0]    b_base_r;
    logic [LEN_WIDTH-1:0]     len_r;
    logic [LEN_WIDTH-1:0]     idx;
    logic [HV_DATA_WIDTH-1:0] a_hold;
    logic [HV_DATA_WIDTH-1:0] b_hold;
    logic                     start_ok;
    logic                     last_pair;
    logic                     timeout;
    logic [ADDR_WIDTH-1:0]    idx_addr;

    assign start_ok  = start && (length != '0);
    assign last_pair = (idx == (len_r - LEN_WIDTH'(1)));
    assign idx_addr  = idx[ADDR_WIDTH-1:0];
    assign busy      = (state != S_IDLE);

`ifdef HV_PAIR_STREAMER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;

    assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout = wd_hit && (((state == S_WAIT_RDY) && !sim_ready) ||
                                ((state == S_WAIT_DONE) && !sim_done));

    // Counts cycles spent in a wait state; any state change restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state_next != state) begin
            wd_cnt <= '0;
        end else if ((state == S_WAIT_RDY) || (state == S_WAIT_DONE)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else if ((state == S_IDLE) && start_ok) begin
            error <= 1'b0;
        end else if (timeout) begin
            error <= 1'b1;
        end
    end
`else
    logic wd_unused;

    assign wd_unused = (TIMEOUT_CYCLES != 0);
    assign timeout   = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        sim_valid  = 1'b0;
        sim_first  = 1'b0;
        sim_last   = 1'b0;
        sim_data   = '0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_FETCH_A;
            end
            S_FETCH_A: begin
                mem_rd     = 1'b1;
                mem_addr   = a_base_r + idx_addr;
                state_next = S_FETCH_B;
            end
            S_FETCH_B: begin
                mem_rd     = 1'b1;
                mem_addr   = b_base_r + idx_addr;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (sim_ready)    state_next = S_SEND_A;
                else if (timeout) state_next = S_IDLE;
            end
            S_SEND_A: begin
                sim_valid  = 1'b1;
                sim_data   = a_hold;
                sim_first  = (idx == '0);
                sim_last   = last_pair;
                state_next = S_SEND_B;
            end
            S_SEND_B: begin
                sim_valid  = 1'b1;
                sim_data   = b_hold;
                sim_last   = last_pair;
                state_next = S_GUARD;
            end
            // Ready is ignored here: the accumulator's ready drop is registered.
            S_GUARD: begin
                state_next = last_pair ? S_WAIT_DONE : S_FETCH_A;
            end
            S_WAIT_DONE: begin
                if (sim_done)     state_next = S_IDLE;
                else if (timeout) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, element index, holding registers and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_base_r     <= '0;
            b_base_r     <= '0;
            len_r        <= '0;
            idx          <= '0;
            a_hold       <= '0;
            b_hold       <= '0;
            res_AA       <= '0;
            res_BB       <= '0;
            res_AB       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        a_base_r <= a_base;
                        b_base_r <= b_base;
                        len_r    <= length;
                        idx      <= '0;
                    end
                end
                S_FETCH_B: a_hold <= mem_rdata;
                S_LOAD:    b_hold <= mem_rdata;
                S_GUARD: begin
                    if (!last_pair) idx <= idx + LEN_WIDTH'(1);
                end
                S_WAIT_DONE: begin
                    if (sim_done) begin
                        res_AA       <= sim_AA;
                        res_BB       <= sim_BB;
                        res_AB       <= sim_AB;
                        result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_pair_streamer.sv
// Self-checking bench for hv_pair_streamer: directed test-plan cases plus randomized transfers
// checked against a queue-based model of the expected beat and address streams.
module tb_hv_pair_streamer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int TO = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
        int            cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [LW-1:0] length;
    logic          busy;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          sim_valid;
    logic          sim_first;
    logic          sim_last;
    logic [DW-1:0] sim_data;
    logic          sim_ready;
    logic          sim_done;
    logic [DW-1:0] sim_AA;
    logic [DW-1:0] sim_BB;
    logic [DW-1:0] sim_AB;
    logic [DW-1:0] res_AA;
    logic [DW-1:0] res_BB;
    logic [DW-1:0] res_AB;
    logic          result_valid;
    logic          error;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc_count    = 0;
    int rv_count     = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    beat_t         got_beats[$];
    logic [AW-1:0] got_addrs[$];

    hv_pair_streamer #(
        .HV_DATA_WIDTH (DW),
        .ADDR_WIDTH    (AW),
        .LEN_WIDTH     (LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a_base      (a_base),
        .b_base      (b_base),
        .length      (length),
        .busy        (busy),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .sim_valid   (sim_valid),
        .sim_first   (sim_first),
        .sim_last    (sim_last),
        .sim_data    (sim_data),
        .sim_ready   (sim_ready),
        .sim_done    (sim_done),
        .sim_AA      (sim_AA),
        .sim_BB      (sim_BB),
        .sim_AB      (sim_AB),
        .res_AA      (res_AA),
        .res_BB      (res_BB),
        .res_AB      (res_AB),
        .result_valid(result_valid),
        .error       (error)
    );

    always #5 clk = ~clk;

    // One-cycle-latency element memory.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Monitor: records beats, read addresses and result strobes away from the active edge.
    always @(negedge clk) begin
        cyc_count <= cyc_count + 1;
        if (sim_valid === 1'b1) got_beats.push_back('{sim_data, sim_first, sim_last, cyc_count});
        if (mem_rd === 1'b1) got_addrs.push_back(mem_addr);
        if (result_valid === 1'b1) rv_count <= rv_count + 1;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [LW-1:0] n);
        @(negedge clk);
        a_base = ab;
        b_base = bb;
        length = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic runTransfer(input string name, input int ab, input int bb, input int n,
                               input int ready_hold, input bit rand_ready, input bit busy_start,
                               input logic [DW-1:0] s_aa, input logic [DW-1:0] s_bb, input logic [DW-1:0] s_ab);
        beat_t         exp_beats[$];
        logic [AW-1:0] exp_addrs[$];
        int            cyc;
        int            hold_valid;
        int            beat_base;
        int            addr_base;
        int            rv_base;
        int            got_n;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] pa;
            logic [AW-1:0] pb;
            pa = AW'((ab + i) % (1 << AW));
            pb = AW'((bb + i) % (1 << AW));
            exp_addrs.push_back(pa);
            exp_addrs.push_back(pb);
            exp_beats.push_back('{mem[pa], (i == 0), (i == n - 1), 0});
            exp_beats.push_back('{mem[pb], 1'b0, (i == n - 1), 0});
        end
        beat_base = got_beats.size();
        addr_base = got_addrs.size();
        rv_base   = rv_count;
        sim_ready = (ready_hold == 0);
        applyStimulus(AW'(ab), AW'(bb), LW'(n));
        checkOutput({name, "_busy"}, 64'(busy), 64'(1));

        if (ready_hold > 0) begin
            hold_valid = 0;
            repeat (ready_hold) begin
                @(negedge clk);
                if (sim_valid !== 1'b0) hold_valid++;
            end
            checkOutput({name, "_hold_novalid"}, 64'(hold_valid), 64'(0));
            sim_ready = 1'b1;
            @(negedge clk);
            checkOutput({name, "_hold_abeat"}, 64'({sim_valid, sim_first}), 64'(2'b11));
        end

        cyc = 0;
        while ((got_beats.size() - beat_base) < 2 * n && cyc < 60 * n + 100) begin
            @(negedge clk);
            cyc++;
            if (rand_ready) sim_ready = ($urandom_range(0, 3) != 0);
            if (busy_start && cyc == 3) begin
                start  = 1'b1;
                a_base = AW'($urandom);
                b_base = AW'($urandom);
                length = LW'(1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({name, "_beats_in_time"}, 64'(cyc < 60 * n + 100), 64'(1));

        sim_ready = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sim_AA   = s_aa;
        sim_BB   = s_bb;
        sim_AB   = s_ab;
        sim_done = 1'b1;
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_rv"}, 64'(result_valid), 64'(1));
        checkOutput({name, "_res_AA"}, 64'(res_AA), 64'(s_aa));
        checkOutput({name, "_res_BB"}, 64'(res_BB), 64'(s_bb));
        checkOutput({name, "_res_AB"}, 64'(res_AB), 64'(s_ab));
        checkOutput({name, "_busy_end"}, 64'(busy), 64'(0));
        sim_done = 1'b0;
        @(negedge clk);
        checkOutput({name, "_rv_pulse"}, 64'(result_valid), 64'(0));
        repeat (3) @(negedge clk);
        checkOutput({name, "_rv_count"}, 64'(rv_count - rv_base), 64'(1));

        got_n = got_beats.size() - beat_base;
        checkOutput({name, "_beat_count"}, 64'(got_n), 64'(2 * n));
        for (int k = 0; k < 2 * n && k < got_n; k++) begin
            checkOutput($sformatf("%s_data%0d", name, k), 64'(got_beats[beat_base + k].data), 64'(exp_beats[k].data));
            checkOutput($sformatf("%s_first%0d", name, k), 64'(got_beats[beat_base + k].first), 64'(exp_beats[k].first));
            checkOutput($sformatf("%s_last%0d", name, k), 64'(got_beats[beat_base + k].last), 64'(exp_beats[k].last));
            if (k % 2 == 1)
                checkOutput($sformatf("%s_b2b%0d", name, k),
                            64'(got_beats[beat_base + k].cyc - got_beats[beat_base + k - 1].cyc), 64'(1));
        end
        got_n = got_addrs.size() - addr_base;
        checkOutput({name, "_addr_count"}, 64'(got_n), 64'(2 * n));
        for (int k = 0; k < 2 * n && k < got_n; k++)
            checkOutput($sformatf("%s_addr%0d", name, k), 64'(got_addrs[addr_base + k]), 64'(exp_addrs[k]));
    endtask

    initial begin
        int cyc;
        int rv_base;
        reset     = 1'b1;
        start     = 1'b0;
        a_base    = '0;
        b_base    = '0;
        length    = '0;
        sim_ready = 1'b0;
        sim_done  = 1'b0;
        sim_AA    = '0;
        sim_BB    = '0;
        sim_AB    = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[10'h010] = 32'h3F80_0000;
        mem[10'h011] = 32'h4000_0000;
        mem[10'h020] = 32'h4040_0000;
        mem[10'h021] = 32'h4080_0000;
        mem[10'h030] = 32'h4000_0000;
        mem[10'h040] = 32'h4000_0000;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_valid", 64'(sim_valid), 64'(0));
        checkOutput("rst_mem_rd", 64'(mem_rd), 64'(0));
        checkOutput("rst_rv", 64'(result_valid), 64'(0));
        checkOutput("rst_res", 64'({res_AA, res_BB}), 64'(0));
        checkOutput("rst_error", 64'(error), 64'(0));

        runTransfer("n2", 'h010, 'h020, 2, 0, 0, 0, 32'h40A0_0000, 32'h41C8_0000, 32'h4130_0000);
        runTransfer("n1", 'h030, 'h040, 1, 0, 0, 0, 32'h4080_0000, 32'h4080_0000, 32'h4080_0000);
        runTransfer("wrap", 'h3FF, 'h100, 3, 0, 0, 0, DW'($urandom), DW'($urandom), DW'($urandom));
        runTransfer("hold", 'h200, 'h300, 2, 10, 0, 0, DW'($urandom), DW'($urandom), DW'($urandom));

        applyStimulus(10'h000, 10'h000, 11'd0);
        checkOutput("len0_ignored", 64'(busy), 64'(0));

        for (int t = 0; t < 6; t++)
            runTransfer($sformatf("rnd%0d", t), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                        int'($urandom_range(1, 6)), 0, 1, (t % 2 == 1), DW'($urandom), DW'($urandom), DW'($urandom));

        sim_ready = 1'b1;
        applyStimulus(10'h050, 10'h060, 11'd3);
        cyc = 0;
        while (sim_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midrst_abeat", 64'({sim_valid, sim_first}), 64'(2'b11));
        @(negedge clk);
        checkOutput("midrst_bbeat", 64'({sim_valid, sim_first}), 64'(2'b10));
        rv_base = rv_count;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_valid", 64'(sim_valid), 64'(0));
        checkOutput("midrst_res", 64'({res_AA, res_BB}), 64'(0));
        checkOutput("midrst_res_ab", 64'(res_AB), 64'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_rv", 64'(rv_count - rv_base), 64'(0));
        runTransfer("after_rst", 'h030, 'h040, 1, 0, 0, 0, 32'h4080_0000, 32'h4080_0000, 32'h4080_0000);

`ifdef HV_PAIR_STREAMER_WATCHDOG_EN
        sim_ready = 1'b1;
        applyStimulus(10'h070, 10'h080, 11'd1);
        cyc = 0;
        while (!(sim_valid === 1'b1 && sim_first === 1'b0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("wd_bbeat", 64'(sim_valid), 64'(1));
        rv_base = rv_count;
        repeat (TO + 1) @(negedge clk);
        checkOutput("wd_not_early", 64'(error), 64'(0));
        checkOutput("wd_busy_early", 64'(busy), 64'(1));
        @(negedge clk);
        checkOutput("wd_error", 64'(error), 64'(1));
        checkOutput("wd_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        checkOutput("wd_no_rv", 64'(rv_count - rv_base), 64'(0));
        applyStimulus(10'h070, 10'h080, 11'd1);
        checkOutput("wd_error_clr", 64'(error), 64'(0));
        cyc = 0;
        while (!(sim_valid === 1'b1 && sim_first === 1'b0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        sim_done = 1'b1;
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("wd_recover_rv", 64'(result_valid), 64'(1));
        sim_done = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
